// File: rtl/instr_fetch_ctrl_if.sv
// Bus between the fetch controller, the instruction ROM, execute redirects and decode.
// Decode handshake: a head entry transfers on a rising edge where out_valid and out_ready are both high.
interface instr_fetch_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] imem_A;
    logic [DATA_WIDTH-1:0]    imem_RD;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     halt;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_instr;
    logic [ADDRESS_WIDTH-1:0] out_pc;
    logic [ADDRESS_WIDTH-1:0] out_pc_plus4;
    logic                     fetching;

    modport master (
        output imem_A,
        input  imem_RD,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output fetching
    );

    modport slave (
        input  imem_A,
        output imem_RD,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  fetching
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, reads the combinational ROM and buffers
// {instr, pc} pairs in a small queue presented to decode.
module instr_fetch_ctrl #(
    parameter int                 DATA_WIDTH    = 32,
    parameter int                 ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'hBFC00000,
    parameter int                 QUEUE_DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_ctrl_if.master   bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_fetching;

    logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0]    r_q_instr [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic                     w_out_valid;
    logic                     w_pop;
    logic                     w_push;

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign w_push      = (r_state == S_RUN) & ~bus.halt & ~bus.redirect_valid
                         & ((r_count < DEPTH_C) | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN:    if (bus.halt && !bus.redirect_valid) w_next_state = S_HALTED;
            S_HALTED: if (!bus.halt) w_next_state = S_RUN;
            default:  w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        w_fetching = (r_state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + ADDRESS_WIDTH'(4);
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= bus.imem_RD;
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign bus.imem_A       = r_fetch_pc;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_instr    = w_out_valid ? r_q_instr[r_rd_ptr] : '0;
    assign bus.out_pc       = w_out_valid ? r_q_pc[r_rd_ptr] : '0;
    assign bus.out_pc_plus4 = w_out_valid ? (r_q_pc[r_rd_ptr] + ADDRESS_WIDTH'(4)) : '0;
    assign bus.fetching     = w_fetching;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: startup, backpressure, redirect, halt, wrap and reset.
module tb_instr_fetch_ctrl;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    instr_fetch_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    instr_fetch_ctrl #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(32),
        .RESET_PC(32'hBFC00000),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ROM contents: a distinct word per address so misordered fetches are visible.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_RD = rom_word(bus.imem_A);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_pc"}, bus.out_pc, pc);
        check({tag, "_instr"}, bus.out_instr, rom_word(pc));
        check({tag, "_pc4"}, bus.out_pc_plus4, pc + 32'd4);
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        rst_n              = 1'b0;
        bus.out_ready      = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();

        // Reset state
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_fetching", {31'd0, bus.fetching}, 32'd1);
        check("rst_imem_a", bus.imem_A, 32'hBFC00000);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_pc4", bus.out_pc_plus4, 32'd0);

        // 1. Streaming with out_ready held high
        rst_n = 1'b1;
        check("t1_valid_c1", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check_head("t1_w0", 32'hBFC00000);
        tick();
        check_head("t1_w1", 32'hBFC00004);
        tick();
        check_head("t1_w2", 32'hBFC00008);
        tick();
        check_head("t1_w3", 32'hBFC0000C);

        // 2. Backpressure after a fresh reset
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        check("t2_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t2_rst_imem_a", bus.imem_A, 32'hBFC00000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_head("t2_hold", 32'hBFC00000);
        check("t2_fetch_hold", bus.imem_A, 32'hBFC00008);
        bus.out_ready = 1'b1;
        check_head("t2_w0", 32'hBFC00000);
        tick();
        check_head("t2_w1", 32'hBFC00004);
        tick();
        check_head("t2_w2", 32'hBFC00008);

        // 4. Full queue with simultaneous push and pop: fetch_pc stays two ahead of head
        check("t4_full_a", bus.imem_A, 32'hBFC00010);
        tick();
        check_head("t4_w3", 32'hBFC0000C);
        check("t4_full_b", bus.imem_A, 32'hBFC00014);

        // 3. Redirect while full; low address bits dropped
        bus.out_ready      = 1'b0;
        tick();
        check("t3_pre_imem_a", bus.imem_A, 32'hBFC00014);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hBFC00103;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        check("t3_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t3_imem_a", bus.imem_A, 32'hBFC00100);
        bus.out_ready = 1'b1;
        tick();
        check_head("t3_tgt0", 32'hBFC00100);
        tick();
        check_head("t3_tgt1", 32'hBFC00104);

        // 5. Halt for three edges mid-stream
        bus.halt = 1'b1;
        tick();
        check("t5_fetching", {31'd0, bus.fetching}, 32'd0);
        check("t5_drained", {31'd0, bus.out_valid}, 32'd0);
        check("t5_pc_frozen", bus.imem_A, 32'hBFC00108);
        tick();
        tick();
        check("t5_still_empty", {31'd0, bus.out_valid}, 32'd0);
        check("t5_pc_frozen2", bus.imem_A, 32'hBFC00108);
        bus.halt = 1'b0;
        tick();
        check("t5_resume_fetching", {31'd0, bus.fetching}, 32'd1);
        tick();
        check_head("t5_resume", 32'hBFC00108);

        // 6. Address wrap, then reset mid-stream
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFFFFFC;
        tick();
        bus.redirect_valid = 1'b0;
        check("t6_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("t6_top_pc", bus.out_pc, 32'hFFFFFFFC);
        check("t6_top_pc4", bus.out_pc_plus4, 32'h00000000);
        check("t6_top_instr", bus.out_instr, rom_word(32'hFFFFFFFC));
        tick();
        check_head("t6_wrap", 32'h00000000);
        check("t6_imem_a", bus.imem_A, 32'h00000004);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6_rst_imem_a", bus.imem_A, 32'hBFC00000);
        check("t6_rst_fetching", {31'd0, bus.fetching}, 32'd1);
        rst_n = 1'b1;
        tick();
        check_head("t6_restart", 32'hBFC00000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
